// File: rtl/arm_dp_pkg.sv
// Shared opcodes, condition codes, FSM encoding and flag indices for the
// ARM data-processing sequencer.
package arm_dp_pkg;

   localparam logic [3:0] OP_AND = 4'h0;
   localparam logic [3:0] OP_EOR = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_RSB = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_ADC = 4'h5;
   localparam logic [3:0] OP_SBC = 4'h6;
   localparam logic [3:0] OP_RSC = 4'h7;
   localparam logic [3:0] OP_TST = 4'h8;
   localparam logic [3:0] OP_TEQ = 4'h9;
   localparam logic [3:0] OP_CMP = 4'hA;
   localparam logic [3:0] OP_CMN = 4'hB;
   localparam logic [3:0] OP_ORR = 4'hC;
   localparam logic [3:0] OP_MOV = 4'hD;
   localparam logic [3:0] OP_BIC = 4'hE;
   localparam logic [3:0] OP_MVN = 4'hF;

   localparam logic [3:0] CC_EQ = 4'h0;
   localparam logic [3:0] CC_NE = 4'h1;
   localparam logic [3:0] CC_CS = 4'h2;
   localparam logic [3:0] CC_CC = 4'h3;
   localparam logic [3:0] CC_MI = 4'h4;
   localparam logic [3:0] CC_PL = 4'h5;
   localparam logic [3:0] CC_VS = 4'h6;
   localparam logic [3:0] CC_VC = 4'h7;
   localparam logic [3:0] CC_HI = 4'h8;
   localparam logic [3:0] CC_LS = 4'h9;
   localparam logic [3:0] CC_GE = 4'hA;
   localparam logic [3:0] CC_LT = 4'hB;
   localparam logic [3:0] CC_GT = 4'hC;
   localparam logic [3:0] CC_LE = 4'hD;
   localparam logic [3:0] CC_AL = 4'hE;
   localparam logic [3:0] CC_NV = 4'hF;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_COND = 2'd1,
      ST_EXEC = 2'd2,
      ST_WB   = 2'd3
   } state_t;

   function automatic logic is_test_op(input logic [3:0] op);
      return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
   endfunction

   function automatic logic is_arith_op(input logic [3:0] op);
      return ((op >= OP_SUB) && (op <= OP_RSC)) || (op == OP_CMP) || (op == OP_CMN);
   endfunction

endpackage

// File: rtl/arm_cond_eval.sv
// Combinational ARM condition-field check against {N,Z,C,V}.
module arm_cond_eval
   import arm_dp_pkg::*;
(
   input  logic [3:0] i_cond,
   input  logic [3:0] i_flags,
   output logic       o_pass
);

   logic w_n, w_z, w_c, w_v;

   assign w_n = i_flags[FLAG_N];
   assign w_z = i_flags[FLAG_Z];
   assign w_c = i_flags[FLAG_C];
   assign w_v = i_flags[FLAG_V];

   always_comb begin
      o_pass = 1'b0;
      case (i_cond)
         CC_EQ: o_pass = w_z;
         CC_NE: o_pass = !w_z;
         CC_CS: o_pass = w_c;
         CC_CC: o_pass = !w_c;
         CC_MI: o_pass = w_n;
         CC_PL: o_pass = !w_n;
         CC_VS: o_pass = w_v;
         CC_VC: o_pass = !w_v;
         CC_HI: o_pass = w_c && !w_z;
         CC_LS: o_pass = !w_c || w_z;
         CC_GE: o_pass = (w_n == w_v);
         CC_LT: o_pass = (w_n != w_v);
         CC_GT: o_pass = !w_z && (w_n == w_v);
         CC_LE: o_pass = w_z || (w_n != w_v);
         CC_AL: o_pass = 1'b1;
         default: o_pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/arm_dp_sequencer.sv
// Steps one data-processing instruction through IDLE/COND/EXEC/WB, driving the
// external ALU from latched fields and owning the architectural NZCV register.
module arm_dp_sequencer
   import arm_dp_pkg::*;
#(
   parameter int          DATA_W    = 32,
   parameter int          RADDR_W   = 4,
   parameter logic [3:0]  FLAGS_RST = 4'b0000
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_instr_valid,
   output logic               o_instr_ready,
   input  logic [3:0]         i_cond,
   input  logic [3:0]         i_opcode,
   input  logic               i_s_bit,
   input  logic [RADDR_W-1:0] i_rd,
   input  logic [DATA_W-1:0]  i_op_a,
   input  logic [DATA_W-1:0]  i_op_b,
   input  logic               i_shifter_carry,
   output logic [3:0]         o_alu_op,
   output logic [DATA_W-1:0]  o_alu_a,
   output logic [DATA_W-1:0]  o_alu_b,
   output logic               o_alu_cin,
   input  logic [DATA_W-1:0]  i_alu_out,
   input  logic               i_alu_cf,
   input  logic               i_alu_nf,
   input  logic               i_alu_vf,
   input  logic               i_alu_zf,
   output logic               o_rf_we,
   output logic [RADDR_W-1:0] o_rf_waddr,
   output logic [DATA_W-1:0]  o_rf_wdata,
   output logic [3:0]         o_flags,
   output logic               o_done,
   output logic               o_skipped
);

   state_t               r_state;
   state_t               w_next;
   logic [3:0]           r_cond;
   logic [3:0]           r_opcode;
   logic                 r_s_bit;
   logic [RADDR_W-1:0]   r_rd;
   logic [DATA_W-1:0]    r_op_a;
   logic [DATA_W-1:0]    r_op_b;
   logic                 r_shc;
   logic [3:0]           r_flags;
   logic                 r_rf_we;
   logic [RADDR_W-1:0]   r_rf_waddr;
   logic [DATA_W-1:0]    r_rf_wdata;
   logic                 r_done;
   logic                 r_skipped;
   logic                 w_pass;
   logic                 w_flag_upd;

   arm_cond_eval u_cond (
      .i_cond  (r_cond),
      .i_flags (r_flags),
      .o_pass  (w_pass)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= ST_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (i_instr_valid) w_next = ST_COND;
         ST_COND: w_next = w_pass ? ST_EXEC : ST_WB;
         ST_EXEC: w_next = ST_WB;
         ST_WB:   w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // In WB the skip marker doubles as the "condition failed" record.
   assign w_flag_upd = (r_state == ST_WB) && !r_skipped && (r_s_bit || is_test_op(r_opcode));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cond     <= '0;
         r_opcode   <= '0;
         r_s_bit    <= 1'b0;
         r_rd       <= '0;
         r_op_a     <= '0;
         r_op_b     <= '0;
         r_shc      <= 1'b0;
         r_flags    <= FLAGS_RST;
         r_rf_we    <= 1'b0;
         r_rf_waddr <= '0;
         r_rf_wdata <= '0;
         r_done     <= 1'b0;
         r_skipped  <= 1'b0;
      end else begin
         r_rf_we   <= 1'b0;
         r_done    <= 1'b0;
         r_skipped <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_instr_valid) begin
                  r_cond   <= i_cond;
                  r_opcode <= i_opcode;
                  r_s_bit  <= i_s_bit;
                  r_rd     <= i_rd;
                  r_op_a   <= i_op_a;
                  r_op_b   <= i_op_b;
                  r_shc    <= i_shifter_carry;
               end
            end
            ST_COND: begin
               if (!w_pass) begin
                  r_done    <= 1'b1;
                  r_skipped <= 1'b1;
               end
            end
            ST_EXEC: begin
               r_done     <= 1'b1;
               r_rf_we    <= !is_test_op(r_opcode);
               r_rf_waddr <= r_rd;
               r_rf_wdata <= i_alu_out;
            end
            default: ;
         endcase

         // ALU inputs are still the latched operands during WB, so its flags are valid here.
         if (w_flag_upd) begin
            r_flags[FLAG_N] <= i_alu_nf;
            r_flags[FLAG_Z] <= i_alu_zf;
            if (is_arith_op(r_opcode)) begin
               r_flags[FLAG_V] <= i_alu_vf;
               r_flags[FLAG_C] <= ((r_opcode == OP_SUB) || (r_opcode == OP_RSB)) ? ~i_alu_cf : i_alu_cf;
            end else begin
               r_flags[FLAG_C] <= r_shc;
            end
         end
      end
   end

   assign o_instr_ready = (r_state == ST_IDLE);
   assign o_alu_op      = r_opcode;
   assign o_alu_a       = r_op_a;
   assign o_alu_b       = r_op_b;
   assign o_alu_cin     = r_flags[FLAG_C];
   assign o_rf_we       = r_rf_we;
   assign o_rf_waddr    = r_rf_waddr;
   assign o_rf_wdata    = r_rf_wdata;
   assign o_flags       = r_flags;
   assign o_done        = r_done;
   assign o_skipped     = r_skipped;

endmodule
